// File: rtl/times_table_axil_slave_if.sv
// AXI4-Lite bus bundle for the times-table slave.
// Carries the five AXI4-Lite channels (AR, R, AW, W, B).
// Modports:
//   slave  - seen from the times-table slave (drives ready/response signals)
//   master - seen from the bus master (drives address/data/valid signals)
interface times_table_axil_slave_if;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;

    modport slave (
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb,
        input  s_axi_wvalid, s_axi_bready,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
    );

    modport master (
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb,
        output s_axi_wvalid, s_axi_bready,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
    );
endinterface

// File: rtl/times_table_axil_slave.sv
// Read-only AXI4-Lite slave returning an 8x8 multiplication table.
// A read of address {24'b0, a[2:0], b[2:0], 2'bxx} returns a*b; any address
// with nonzero bits [31:8] returns DECERR. Writes are accepted and answered
// with SLVERR without changing anything.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   axi  - AXI4-Lite slave bus (times_table_axil_slave_if.slave)
// Parameter:
//   READ_LATENCY - extra wait cycles (0..7) between AR handshake and rvalid
//
// Read FSM:
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_WAIT | address captured, counting down READ_LATENCY cycles
//   R_RESP | rvalid high, holding rdata/rresp until rready
module times_table_axil_slave #(
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    times_table_axil_slave_if.slave axi
);
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;
    localparam logic [2:0] LAT    = 3'(READ_LATENCY);

    logic [1:0]  r_state;
    logic [2:0]  r_count;
    logic [29:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        ready_en;
    logic        ar_hs;

    logic        aw_got;
    logic        w_got;
    logic        aw_hs;
    logic        w_hs;
    logic        b_valid;
    logic [1:0]  b_resp;

    logic        unused_bits;

    // Takes the word address (byte address [31:2]) and returns {rdata, rresp}.
    function automatic logic [33:0] lookup(input logic [29:0] waddr);
        logic [5:0] prod;
        prod = {3'b000, waddr[5:3]} * {3'b000, waddr[2:0]};
        if (waddr[29:6] != 24'd0)
            lookup = {32'd0, 2'b11};
        else
            lookup = {26'd0, prod, 2'b00};
    endfunction

    // ready_en keeps every ready low while reset is held and for the
    // reset edge itself; it rises on the first edge after rst drops.
    assign axi.s_axi_arready = ready_en & (r_state == R_IDLE);
    assign axi.s_axi_rvalid  = (r_state == R_RESP);
    assign axi.s_axi_rdata   = r_data;
    assign axi.s_axi_rresp   = r_resp;
    assign ar_hs             = axi.s_axi_arvalid & axi.s_axi_arready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
            r_state  <= R_IDLE;
            r_count  <= 3'd0;
            r_addr   <= 30'd0;
            r_data   <= 32'd0;
            r_resp   <= 2'b00;
        end else begin
            ready_en <= 1'b1;
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_addr <= axi.s_axi_araddr[31:2];
                        if (LAT == 3'd0) begin
                            {r_data, r_resp} <= lookup(axi.s_axi_araddr[31:2]);
                            r_state          <= R_RESP;
                        end else begin
                            r_count <= LAT;
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_count <= r_count - 3'd1;
                    // Counter reaches zero on this edge: response goes out now.
                    if (r_count == 3'd1) begin
                        {r_data, r_resp} <= lookup(r_addr);
                        r_state          <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (axi.s_axi_rready) begin
                        r_data  <= 32'd0;
                        r_resp  <= 2'b00;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write side: AW and W are latched independently; the response is raised
    // on the same edge that completes the pair so bvalid appears next cycle.
    assign axi.s_axi_awready = ready_en & ~aw_got;
    assign axi.s_axi_wready  = ready_en & ~w_got;
    assign axi.s_axi_bvalid  = b_valid;
    assign axi.s_axi_bresp   = b_resp;
    assign aw_hs             = axi.s_axi_awvalid & axi.s_axi_awready;
    assign w_hs              = axi.s_axi_wvalid & axi.s_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            b_valid <= 1'b0;
            b_resp  <= 2'b00;
        end else if (b_valid) begin
            if (axi.s_axi_bready) begin
                b_valid <= 1'b0;
                b_resp  <= 2'b00;
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
            end
        end else begin
            aw_got <= aw_got | aw_hs;
            w_got  <= w_got | w_hs;
            if ((aw_got | aw_hs) & (w_got | w_hs)) begin
                b_valid <= 1'b1;
                b_resp  <= 2'b10;
            end
        end
    end

    // The table is read-only: write payload and byte-offset bits are ignored.
    assign unused_bits = ^{axi.s_axi_awaddr, axi.s_axi_wdata, axi.s_axi_wstrb,
                           axi.s_axi_araddr[1:0]};
endmodule

// File: tb/tb_times_table_axil_slave.sv
// Self-checking bench for times_table_axil_slave. Three instances with
// READ_LATENCY 0, 1 and 5 share clock and reset; each is driven through its
// own interface instance from per-instance stimulus arrays.
module tb_times_table_axil_slave;
    logic clk;
    logic rst;

    logic [31:0] ar_addr  [3];
    logic        ar_valid [3];
    logic        r_ready  [3];
    logic [31:0] aw_addr  [3];
    logic        aw_valid [3];
    logic [31:0] w_data   [3];
    logic [3:0]  w_strb   [3];
    logic        w_valid  [3];
    logic        b_ready  [3];

    logic [2:0]  ar_ready;
    logic [2:0]  r_valid;
    logic [2:0]  aw_ready;
    logic [2:0]  w_ready;
    logic [2:0]  b_valid;
    logic [31:0] r_data [3];
    logic [1:0]  r_resp [3];
    logic [1:0]  b_resp [3];

    int tests_run;
    int tests_failed;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        times_table_axil_slave_if bus ();
        assign bus.s_axi_araddr  = ar_addr[g];
        assign bus.s_axi_arvalid = ar_valid[g];
        assign bus.s_axi_rready  = r_ready[g];
        assign bus.s_axi_awaddr  = aw_addr[g];
        assign bus.s_axi_awvalid = aw_valid[g];
        assign bus.s_axi_wdata   = w_data[g];
        assign bus.s_axi_wstrb   = w_strb[g];
        assign bus.s_axi_wvalid  = w_valid[g];
        assign bus.s_axi_bready  = b_ready[g];
        assign ar_ready[g]       = bus.s_axi_arready;
        assign r_valid[g]        = bus.s_axi_rvalid;
        assign aw_ready[g]       = bus.s_axi_awready;
        assign w_ready[g]        = bus.s_axi_wready;
        assign b_valid[g]        = bus.s_axi_bvalid;
        assign r_data[g]         = bus.s_axi_rdata;
        assign r_resp[g]         = bus.s_axi_rresp;
        assign b_resp[g]         = bus.s_axi_bresp;

        times_table_axil_slave #(
            .READ_LATENCY((g == 0) ? 0 : ((g == 1) ? 1 : 5))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .axi (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 5);
    endfunction

    // Reference: the table entry for a read address, straight from the rules.
    function automatic void model(input logic [31:0] addr, output logic [31:0] exp_d,
                                  output logic [1:0] exp_r);
        int a;
        int b;
        a = int'(addr[7:5]);
        b = int'(addr[4:2]);
        if (addr[31:8] != 24'd0) begin
            exp_d = 32'd0;
            exp_r = 2'b11;
        end else begin
            exp_d = 32'(a * b);
            exp_r = 2'b00;
        end
    endfunction

    task automatic read_txn(input int d, input logic [31:0] addr, input int hold);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int n;
        int lat;
        model(addr, exp_d, exp_r);
        r_ready[d]  = (hold == 0);
        ar_addr[d]  = addr;
        ar_valid[d] = 1'b1;
        n = 0;
        while (ar_ready[d] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (ar_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL arready_wait dut%0d: arready=%b required 1", d, ar_ready[d]);
            ar_valid[d] = 1'b0;
            return;
        end
        step();
        ar_valid[d] = 1'b0;
        ar_addr[d]  = $urandom;
        lat = 1;
        while (r_valid[d] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != lat_of(d) + 1) begin
            tests_failed++;
            $display("FAIL read_latency dut%0d addr=%h: got %0d cycles required %0d",
                     d, addr, lat, lat_of(d) + 1);
        end
        tests_run++;
        if (r_data[d] !== exp_d || r_resp[d] !== exp_r) begin
            tests_failed++;
            $display("FAIL read_data dut%0d addr=%h: got %0d/%b required %0d/%b",
                     d, addr, r_data[d], r_resp[d], exp_d, exp_r);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            tests_run++;
            if (r_valid[d] !== 1'b1 || r_data[d] !== exp_d || r_resp[d] !== exp_r ||
                ar_ready[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL read_hold dut%0d: got v=%b d=%0d r=%b ar=%b required 1/%0d/%b/0",
                         d, r_valid[d], r_data[d], r_resp[d], ar_ready[d], exp_d, exp_r);
            end
        end
        r_ready[d] = 1'b1;
        step();
        tests_run++;
        if (r_valid[d] !== 1'b0 || r_data[d] !== 32'd0 || r_resp[d] !== 2'b00 ||
            ar_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_complete dut%0d: got v=%b d=%0d r=%b ar=%b required 0/0/00/1",
                     d, r_valid[d], r_data[d], r_resp[d], ar_ready[d]);
        end
        r_ready[d] = 1'b0;
    endtask

    task automatic write_txn(input int d, input int w_dly, input int aw_dly, input int bhold);
        int  c;
        int  first_b;
        int  exp_b;
        bit  aw_taken;
        bit  w_taken;
        exp_b    = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
        first_b  = -1;
        c        = 0;
        aw_taken = 1'b0;
        w_taken  = 1'b0;
        b_ready[d] = (bhold == 0);
        while (first_b < 0 && c < 30) begin
            aw_valid[d] = (c >= aw_dly) && !aw_taken;
            w_valid[d]  = (c >= w_dly) && !w_taken;
            aw_addr[d]  = $urandom;
            w_data[d]   = $urandom;
            w_strb[d]   = 4'($urandom);
            if (aw_valid[d] && aw_ready[d]) aw_taken = 1'b1;
            if (w_valid[d] && w_ready[d]) w_taken = 1'b1;
            step();
            c++;
            if (b_valid[d] === 1'b1) first_b = c;
        end
        aw_valid[d] = 1'b0;
        w_valid[d]  = 1'b0;
        tests_run++;
        if (first_b != exp_b) begin
            tests_failed++;
            $display("FAIL write_bvalid_cycle dut%0d: got cycle %0d required %0d", d, first_b, exp_b);
        end
        tests_run++;
        if (b_resp[d] !== 2'b10 || aw_ready[d] !== 1'b0 || w_ready[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_bresp dut%0d: got bresp=%b aw=%b w=%b required 10/0/0",
                     d, b_resp[d], aw_ready[d], w_ready[d]);
        end
        for (int i = 0; i < bhold; i++) begin
            step();
            tests_run++;
            if (b_valid[d] !== 1'b1 || b_resp[d] !== 2'b10) begin
                tests_failed++;
                $display("FAIL write_hold dut%0d: got bvalid=%b bresp=%b required 1/10",
                         d, b_valid[d], b_resp[d]);
            end
        end
        b_ready[d] = 1'b1;
        step();
        tests_run++;
        if (b_valid[d] !== 1'b0 || b_resp[d] !== 2'b00 || aw_ready[d] !== 1'b1 ||
            w_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_complete dut%0d: got bvalid=%b bresp=%b aw=%b w=%b required 0/00/1/1",
                     d, b_valid[d], b_resp[d], aw_ready[d], w_ready[d]);
        end
        b_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if ({ar_ready[d], aw_ready[d], w_ready[d]} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_ready dut%0d: got %b required 000", d,
                         {ar_ready[d], aw_ready[d], w_ready[d]});
            end
            tests_run++;
            if (r_valid[d] !== 1'b0 || b_valid[d] !== 1'b0 || r_data[d] !== 32'd0 ||
                r_resp[d] !== 2'b00 || b_resp[d] !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_outputs dut%0d: got rv=%b bv=%b rd=%0d rr=%b br=%b required zeros",
                         d, r_valid[d], b_valid[d], r_data[d], r_resp[d], b_resp[d]);
            end
        end
        rst = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if ({ar_ready[d], aw_ready[d], w_ready[d]} !== 3'b111) begin
                tests_failed++;
                $display("FAIL reset_release dut%0d: got %b required 111", d,
                         {ar_ready[d], aw_ready[d], w_ready[d]});
            end
        end
    endtask

    task automatic test_latency_one();
        read_txn(1, 32'h0000_00F4, 0);
    endtask

    task automatic test_table_sweep();
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                read_txn(0, {24'd0, 3'(a), 3'(b), 2'b00}, 0);
    endtask

    task automatic test_decerr_hold();
        read_txn(1, 32'h0000_01FC, 5);
    endtask

    task automatic test_write_then_read();
        write_txn(1, 0, 3, 2);
        read_txn(1, {24'd0, 3'd3, 3'd3, 2'b00}, 0);
    endtask

    task automatic test_random();
        int          d;
        logic [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) addr = {24'd0, 8'($urandom)};
            else addr = $urandom;
            read_txn(d, addr, int'($urandom_range(0, 3)));
            write_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_concurrent();
        int          rf;
        int          bf;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        for (int d = 0; d < 3; d++) begin
            ar_addr[d]  = {24'd0, 3'd6, 3'd6, 2'b00};
            ar_valid[d] = 1'b1;
            aw_valid[d] = 1'b1;
            w_valid[d]  = 1'b1;
            r_ready[d]  = 1'b1;
            b_ready[d]  = 1'b1;
            step();
            ar_valid[d] = 1'b0;
            aw_valid[d] = 1'b0;
            w_valid[d]  = 1'b0;
            rf = -1;
            bf = -1;
            rd = 32'd0;
            rr = 2'b00;
            br = 2'b00;
            for (int c = 1; c <= 12; c++) begin
                if (r_valid[d] === 1'b1 && rf < 0) begin
                    rf = c;
                    rd = r_data[d];
                    rr = r_resp[d];
                end
                if (b_valid[d] === 1'b1 && bf < 0) begin
                    bf = c;
                    br = b_resp[d];
                end
                step();
            end
            tests_run++;
            if (rf != lat_of(d) + 1 || rd !== 32'd36 || rr !== 2'b00) begin
                tests_failed++;
                $display("FAIL concurrent_read dut%0d: got cycle %0d data %0d resp %b required %0d/36/00",
                         d, rf, rd, rr, lat_of(d) + 1);
            end
            tests_run++;
            if (bf != 1 || br !== 2'b10) begin
                tests_failed++;
                $display("FAIL concurrent_write dut%0d: got cycle %0d bresp %b required 1/10", d, bf, br);
            end
            r_ready[d] = 1'b0;
            b_ready[d] = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        ar_addr[2]  = 32'h0000_00FC;
        ar_valid[2] = 1'b1;
        r_ready[2]  = 1'b1;
        aw_valid[1] = 1'b1;
        w_valid[1]  = 1'b1;
        b_ready[1]  = 1'b0;
        step();
        ar_valid[2] = 1'b0;
        aw_valid[1] = 1'b0;
        w_valid[1]  = 1'b0;
        step();
        step();
        tests_run++;
        if (b_valid[1] !== 1'b1 || r_valid[2] !== 1'b0 || ar_ready[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_setup: got bvalid=%b rvalid=%b arready=%b required 1/0/0",
                     b_valid[1], r_valid[2], ar_ready[2]);
        end
        rst = 1'b1;
        step();
        tests_run++;
        if (ar_ready[2] !== 1'b0 || r_valid[2] !== 1'b0 || b_valid[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_in_reset: got arready=%b rvalid=%b bvalid=%b required 0/0/0",
                     ar_ready[2], r_valid[2], b_valid[1]);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (ar_ready[2] !== 1'b1 || aw_ready[1] !== 1'b1 || w_ready[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_release: got arready=%b awready=%b wready=%b required 1/1/1",
                     ar_ready[2], aw_ready[1], w_ready[1]);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            tests_run++;
            if (r_valid[2] !== 1'b0 || b_valid[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_quiet cycle %0d: got rvalid=%b bvalid=%b required 0/0",
                         i, r_valid[2], b_valid[1]);
            end
        end
        r_ready[2] = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        for (int d = 0; d < 3; d++) begin
            ar_addr[d]  = 32'd0;
            ar_valid[d] = 1'b0;
            r_ready[d]  = 1'b0;
            aw_addr[d]  = 32'd0;
            aw_valid[d] = 1'b0;
            w_data[d]   = 32'd0;
            w_strb[d]   = 4'd0;
            w_valid[d]  = 1'b0;
            b_ready[d]  = 1'b0;
        end
        test_reset();
        test_latency_one();
        test_table_sweep();
        test_decerr_hold();
        test_write_then_read();
        test_random();
        test_concurrent();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
